// File: rtl/ulpb_rx_buffer.sv
// ulpb_rx_buffer
//   Receive-side message buffer between the ulpb_node receive port and the
//   AHB read path. Completes the node's four-phase REQ_RX/ACK_RX handshake,
//   queues each address/data pair in a DEPTH-entry FIFO and presents the head
//   entry to the bus-side consumer through a valid/pop interface.
//
// Ports
//   CLK, RESET        clock shared with ulpb_node; async active-high reset
//   REQ_RX, ACK_RX    node handshake (ACK_RX held until REQ_RX is seen low)
//   ADDR_IN, DATA_IN  message from the node, sampled on the push edge
//   RD_POP            consumer removes the head entry
//   RD_VALID          FIFO non-empty; RD_ADDR/RD_DATA hold the head entry
//   LEVEL             current entry count, 0..DEPTH
//   RX_INT            level interrupt while messages are pending
//   STALL             node is requesting while the FIFO is full
//
// Optional build macro ULPB_RXBUF_STATS_EN adds
//   RX_COUNT [15:0]   wrapping count of accepted messages
//   RX_COUNT_CLR      synchronous clear of RX_COUNT (wins over a push)

module ulpb_rx_buffer #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_RX,
  output logic              ACK_RX,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              RD_POP,
  output logic              RD_VALID,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [PTR_W:0]    LEVEL,
  output logic              RX_INT,
  output logic              STALL
`ifdef ULPB_RXBUF_STATS_EN
  ,
  output logic [15:0]       RX_COUNT,
  input  logic              RX_COUNT_CLR
`endif
);

  localparam int            ENTRY_W  = ADDR_W + DATA_W;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle cannot make room for a push until the following cycle.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = (state_q == IDLE) && REQ_RX && !full;
  assign pop   = RD_POP && !empty;

  // Handshake FSM: one write per REQ_RX assertion, ACK_RX held until the
  // node withdraws its request.
  always_comb begin
    state_d = state_q;
    STALL   = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ_RX) begin
          if (full) STALL = 1'b1;
          else      state_d = ACK;
        end
      end
      ACK: begin
        if (!REQ_RX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; the count alone defines validity.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {ADDR_IN, DATA_IN};
  end

  // ACK_RX is the ACK state bit itself, so it is a clean flop output that
  // drops asynchronously with RESET.
  assign ACK_RX   = (state_q == ACK);
  assign RD_VALID = !empty;
  assign RX_INT   = !empty;
  assign LEVEL    = count_q;
  assign RD_ADDR  = mem_q[rd_ptr_q][ENTRY_W-1:DATA_W];
  assign RD_DATA  = mem_q[rd_ptr_q][DATA_W-1:0];

`ifdef ULPB_RXBUF_STATS_EN
  logic [15:0] rx_count_q, rx_count_d;

  always_comb begin
    rx_count_d = rx_count_q;
    if (RX_COUNT_CLR)  rx_count_d = '0;
    else if (push)     rx_count_d = rx_count_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rx_count_q <= '0;
    else       rx_count_q <= rx_count_d;
  end

  assign RX_COUNT = rx_count_q;
`endif

endmodule

// File: tb/tb_ulpb_rx_buffer.sv
module tb_ulpb_rx_buffer;

  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              REQ_RX;
  logic              ACK_RX;
  logic [ADDR_W-1:0] ADDR_IN;
  logic [DATA_W-1:0] DATA_IN;
  logic              RD_POP;
  logic              RD_VALID;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [DATA_W-1:0] RD_DATA;
  logic [PTR_W:0]    LEVEL;
  logic              RX_INT;
  logic              STALL;
`ifdef ULPB_RXBUF_STATS_EN
  logic [15:0]       RX_COUNT;
  logic              RX_COUNT_CLR;
`endif

  int errors = 0;
  int checks = 0;

  ulpb_rx_buffer #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ_RX  (REQ_RX),
    .ACK_RX  (ACK_RX),
    .ADDR_IN (ADDR_IN),
    .DATA_IN (DATA_IN),
    .RD_POP  (RD_POP),
    .RD_VALID(RD_VALID),
    .RD_ADDR (RD_ADDR),
    .RD_DATA (RD_DATA),
    .LEVEL   (LEVEL),
    .RX_INT  (RX_INT),
    .STALL   (STALL)
`ifdef ULPB_RXBUF_STATS_EN
    ,
    .RX_COUNT    (RX_COUNT),
    .RX_COUNT_CLR(RX_COUNT_CLR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full four-phase handshake: raise REQ_RX, wait for ACK_RX, drop REQ_RX,
  // wait for ACK_RX to fall. Each wait is bounded.
  task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    REQ_RX  = 1'b1;
    ADDR_IN = a;
    DATA_IN = d;
    n = 0;
    while (ACK_RX !== 1'b1 && n < 20) begin tick(); n++; end
    chk("send_ack_rise", {63'd0, ACK_RX}, 64'd1);
    REQ_RX = 1'b0;
    n = 0;
    while (ACK_RX !== 1'b0 && n < 20) begin tick(); n++; end
    chk("send_ack_fall", {63'd0, ACK_RX}, 64'd0);
  endtask

  task automatic pop1();
    RD_POP = 1'b1;
    tick();
    RD_POP = 1'b0;
  endtask

  initial begin
    RESET   = 1'b1;
    REQ_RX  = 1'b0;
    ADDR_IN = '0;
    DATA_IN = '0;
    RD_POP  = 1'b0;
`ifdef ULPB_RXBUF_STATS_EN
    RX_COUNT_CLR = 1'b0;
`endif
    tick();
    tick();
    RESET = 1'b0;
    tick();

    // Reset state
    chk("rst_ack",   {63'd0, ACK_RX},   64'd0);
    chk("rst_level", {61'd0, LEVEL},    64'd0);
    chk("rst_valid", {63'd0, RD_VALID}, 64'd0);
    chk("rst_int",   {63'd0, RX_INT},   64'd0);
    chk("rst_stall", {63'd0, STALL},    64'd0);
`ifdef ULPB_RXBUF_STATS_EN
    chk("rst_rxcount", {48'd0, RX_COUNT}, 64'd0);
`endif

    // Single message
    REQ_RX  = 1'b1;
    ADDR_IN = 8'hAB;
    DATA_IN = 32'hDEADBEEF;
    tick();
    chk("single_ack",   {63'd0, ACK_RX},   64'd1);
    chk("single_valid", {63'd0, RD_VALID}, 64'd1);
    chk("single_addr",  {56'd0, RD_ADDR},  64'hAB);
    chk("single_data",  {32'd0, RD_DATA},  64'hDEADBEEF);
    chk("single_level", {61'd0, LEVEL},    64'd1);
    chk("single_int",   {63'd0, RX_INT},   64'd1);
    REQ_RX = 1'b0;
    tick();
    chk("single_ack_fall", {63'd0, ACK_RX}, 64'd0);
    chk("single_level2",   {61'd0, LEVEL},  64'd1);
    pop1();
    chk("single_pop_valid", {63'd0, RD_VALID}, 64'd0);
    chk("single_pop_level", {61'd0, LEVEL},    64'd0);
    chk("single_pop_int",   {63'd0, RX_INT},   64'd0);

    // Fill to full, then stall
    for (int i = 1; i <= 4; i++) send(8'(i), 32'(i));
    chk("fill_level", {61'd0, LEVEL}, 64'd4);
    REQ_RX  = 1'b1;
    ADDR_IN = 8'd5;
    DATA_IN = 32'd5;
    #1;
    chk("full_stall", {63'd0, STALL}, 64'd1);
    begin
      int acks;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (ACK_RX !== 1'b0) acks++;
      end
      chk("full_no_ack", 64'(acks), 64'd0);
    end
    chk("full_level_hold", {61'd0, LEVEL}, 64'd4);
    chk("full_stall_hold", {63'd0, STALL}, 64'd1);
    // Pop frees a slot; the push happens on the following edge
    pop1();
    chk("full_pop_level", {61'd0, LEVEL},  64'd3);
    chk("full_pop_ack",   {63'd0, ACK_RX}, 64'd0);
    chk("full_pop_stall", {63'd0, STALL},  64'd0);
    tick();
    chk("full_5th_ack",   {63'd0, ACK_RX}, 64'd1);
    chk("full_5th_level", {61'd0, LEVEL},  64'd4);
    REQ_RX = 1'b0;
    tick();
    for (int i = 2; i <= 5; i++) begin
      chk("full_order_data", {32'd0, RD_DATA}, 64'(i));
      chk("full_order_addr", {56'd0, RD_ADDR}, 64'(i));
      pop1();
    end
    chk("full_drain_level", {61'd0, LEVEL}, 64'd0);

    // Long REQ_RX: one entry only
    REQ_RX  = 1'b1;
    ADDR_IN = 8'h77;
    DATA_IN = 32'h77;
    for (int i = 0; i < 20; i++) tick();
    chk("long_level", {61'd0, LEVEL},  64'd1);
    chk("long_ack",   {63'd0, ACK_RX}, 64'd1);
    REQ_RX = 1'b0;
    tick();
    chk("long_level2", {61'd0, LEVEL}, 64'd1);
    chk("long_head",   {32'd0, RD_DATA}, 64'h77);

    // Push and pop on the same edge with LEVEL=1
    REQ_RX  = 1'b1;
    ADDR_IN = 8'h88;
    DATA_IN = 32'h88;
    RD_POP  = 1'b1;
    tick();
    RD_POP  = 1'b0;
    chk("pp_level", {61'd0, LEVEL},   64'd1);
    chk("pp_head",  {32'd0, RD_DATA}, 64'h88);
    chk("pp_ack",   {63'd0, ACK_RX},  64'd1);
    REQ_RX = 1'b0;
    tick();
    pop1();
    chk("pp_empty", {61'd0, LEVEL}, 64'd0);

    // Pop on empty is ignored
    RD_POP = 1'b1;
    tick();
    tick();
    RD_POP = 1'b0;
    chk("uflow_level", {61'd0, LEVEL},    64'd0);
    chk("uflow_valid", {63'd0, RD_VALID}, 64'd0);

    // Wrap-around: pointers circle the ring several times
    for (int i = 0; i < 10; i++) begin
      send(8'(8'h40 + i), 32'(i));
      chk("wrap_level", {61'd0, LEVEL},   64'd1);
      chk("wrap_data",  {32'd0, RD_DATA}, 64'(i));
      chk("wrap_addr",  {56'd0, RD_ADDR}, 64'(8'h40 + i));
      pop1();
    end
    chk("wrap_end_level", {61'd0, LEVEL}, 64'd0);

    // Asynchronous reset in the middle of ACK
    REQ_RX  = 1'b1;
    ADDR_IN = 8'h99;
    DATA_IN = 32'h99;
    tick();
    chk("arst_pre_ack", {63'd0, ACK_RX}, 64'd1);
    RESET = 1'b1;
    #1;
    chk("arst_ack",   {63'd0, ACK_RX},   64'd0);
    chk("arst_level", {61'd0, LEVEL},    64'd0);
    chk("arst_valid", {63'd0, RD_VALID}, 64'd0);
    REQ_RX = 1'b0;
    tick();
    RESET = 1'b0;
    tick();
    chk("arst_post_level", {61'd0, LEVEL}, 64'd0);

`ifdef ULPB_RXBUF_STATS_EN
    // Statistics counter: three pushes, then a clear on a push edge
    chk("stats_after_rst", {48'd0, RX_COUNT}, 64'd0);
    for (int i = 0; i < 3; i++) send(8'(i), 32'(i));
    chk("stats_count3", {48'd0, RX_COUNT}, 64'd3);
    REQ_RX       = 1'b1;
    RX_COUNT_CLR = 1'b1;
    tick();
    RX_COUNT_CLR = 1'b0;
    chk("stats_clr_ack",   {63'd0, ACK_RX},  64'd1);
    chk("stats_clr_wins",  {48'd0, RX_COUNT}, 64'd0);
    chk("stats_clr_level", {61'd0, LEVEL},    64'd4);
    REQ_RX = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ulpb_rx_buffer.md
Name: ulpb_rx_buffer

Overview:
Receive-side message buffer between the ulpb_node receive port (ADDR_OUT/DATA_OUT/REQ_RX/ACK_RX) and the AHB interface read path. It completes the node's four-phase REQ/ACK handshake, stores each received address/data pair in a small FIFO, and presents the head entry to the bus-side consumer through a valid/pop interface. It raises a level interrupt while messages are pending. It decouples node receive timing from slow AHB readout and applies backpressure when full.

Parameters:
DEPTH, 4, number of FIFO entries; power of 2, minimum 2
PTR_W, 2, log2(DEPTH); must match DEPTH
ADDR_W, 8, message address width
DATA_W, 32, message data width

Ports:
CLK  input  1  clock shared with ulpb_node
RESET  input  1  asynchronous, active-high reset
REQ_RX  input  1  node has a message on ADDR_IN/DATA_IN
ACK_RX  output  1  message accepted; returned to node
ADDR_IN  input  ADDR_W  node ADDR_OUT
DATA_IN  input  DATA_W  node DATA_OUT
RD_POP  input  1  consumer removes head entry
RD_VALID  output  1  FIFO non-empty; head valid
RD_ADDR  output  ADDR_W  head entry address
RD_DATA  output  DATA_W  head entry data
LEVEL  output  PTR_W+1  current entry count, 0..DEPTH
RX_INT  output  1  pending-message interrupt, equals RD_VALID
STALL  output  1  REQ_RX high in IDLE while FIFO full

Behaviour:
- Reset (async assert, sync release): ACK_RX=0, LEVEL=0, RD_VALID=0, RX_INT=0, STALL=0, pointers=0, FSM=IDLE. RD_ADDR/RD_DATA undefined while RD_VALID=0. Storage contents are not cleared.
- FSM states: IDLE, ACK.
- IDLE, REQ_RX=1, LEVEL<DEPTH at the edge: write {ADDR_IN, DATA_IN} at wr_ptr, wr_ptr+1 (mod DEPTH), count+1, ACK_RX<=1, go to ACK.
- IDLE, REQ_RX=1, LEVEL==DEPTH: no write, ACK_RX stays 0, STALL=1 (combinational), remain in IDLE. The full check uses the registered count only. A pop in the same cycle frees the slot for the next cycle, not this one.
- ACK: hold ACK_RX=1 until REQ_RX is sampled 0, then ACK_RX<=0 and go to IDLE. Exactly one entry is written per REQ_RX assertion, regardless of how long REQ_RX stays high.
- Latency: the push edge is k. From cycle k+1, ACK_RX=1 and the entry is visible (RD_VALID=1 if the FIFO was empty). A new REQ_RX is recognised no earlier than 1 cycle after ACK_RX falls.
- Pop: RD_POP=1 with RD_VALID=1 at an edge: rd_ptr+1 (mod DEPTH), count-1. RD_POP while empty is ignored; no underflow and no pointer movement.
- Simultaneous push and pop: both pointers advance and the count is unchanged. This also holds when LEVEL==DEPTH-1 or when LEVEL==1.
- RD_ADDR/RD_DATA: combinational read of the entry at rd_ptr; stable until the pop edge.
- Pointers are PTR_W wide and wrap naturally. The count is PTR_W+1 wide, so full is distinguished from empty.
- RX_INT = RD_VALID, derived from registers only (glitch-free).
- RESET asserted mid-handshake: ACK_RX drops immediately and the FIFO empties. The node's REQ_RX is then sampled afresh in IDLE, so a message that was still pending is written again.

Optional Feature:
ULPB_RXBUF_STATS_EN:
- Defined: adds output RX_COUNT [15:0] and input RX_COUNT_CLR.
  - RX_COUNT increments by 1 on every push edge and wraps at 16'hFFFF→0.
  - RX_COUNT_CLR=1 sets RX_COUNT to 0. If a push occurs in the same cycle, the clear wins.
  - RX_COUNT resets to 0.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Single message: REQ_RX=1, ADDR_IN=8'hAB, DATA_IN=32'hDEADBEEF, held until ACK_RX → ACK_RX=1 one cycle after the sample edge; RD_VALID=1, RD_ADDR=8'hAB, RD_DATA=32'hDEADBEEF, LEVEL=1, RX_INT=1. Drop REQ_RX → ACK_RX=0 the next cycle. RD_POP for 1 cycle → RD_VALID=0, LEVEL=0.
- Fill to full: 4 handshakes carrying data 1,2,3,4, no pops → LEVEL=4. A 5th REQ_RX → STALL=1, ACK_RX stays 0 for 10 cycles. Pop once → 5th message accepted; LEVEL=4; heads read out in order 2,3,4,5.
- Long REQ_RX: REQ_RX held high for 20 cycles → exactly one entry written, LEVEL=1.
- Push/pop same edge with LEVEL=1: LEVEL stays 1; head advances to the new entry. Pop on empty → LEVEL stays 0, pointers unchanged.
- Wrap-around: 10 push/pop pairs with data 0..9 → consumer sees 0..9 in order; LEVEL returns to 0.
- Async reset mid-ACK: RESET pulsed while ACK_RX=1 → ACK_RX=0 and LEVEL=0 without waiting for a clock edge. With ULPB_RXBUF_STATS_EN: 3 pushes → RX_COUNT=3; clear asserted on a push edge → RX_COUNT=0.
